cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the two result producers, the ALU and the load/store buffer.
- Each source pushes completed results (ROB tag plus value) into its own small FIFO.
- Each cycle the arbiter grants one FIFO head and drives it onto a registered CDB.
- The reservation station and ROB consume the CDB to wake dependent entries and mark completion.

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_arbiter_fifo.sv | 69 ++++++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter slice: default widths, the source
// identifiers and the tie-break helper used by the grant logic.
package cdb_arbiter_pkg;

  localparam int unsigned ID_WIDTH  = 4;
  localparam int unsigned VAL_WIDTH = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  // Chooses the source to pop. With round-robin enabled, a tie goes to the
  // source that was not granted last; otherwise ALU always wins a tie.
  function automatic src_e arb_pick(input logic alu_elig,
                                    input logic lsb_elig,
                                    input logic rr_en,
                                    input src_e last);
    if (alu_elig && lsb_elig)
      return (rr_en && (last == SRC_ALU)) ? SRC_LSB : SRC_ALU;
    else if (lsb_elig)
      return SRC_LSB;
    else
      return SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Small per-source result FIFO {tag, value}. Head is read combinationally
// from the registered read pointer; clear empties it synchronously.
module cdb_fifo #(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned VAL_W = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [TAG_W+VAL_W-1:0]   din,
  output logic [TAG_W+VAL_W-1:0]   dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [TAG_W+VAL_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [PW:0]            r_count;
  logic                   w_do_push;
  logic                   w_do_pop;

  assign full      = (r_count == CNT_FULL);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_push = rdy_in && !clear && push && !full;
  assign w_do_pop  = rdy_in && !clear && pop && !empty;

  // Storage write at the tail; no reset needed since count guards reads.
  always_ff @(posedge clk) begin
    if (!rst_in && w_do_push)
      r_mem[r_wptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
        if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per result source (ALU, LSB), one grant
// per cycle onto a registered CDB. Define CDB_ARB_RR_EN for round-robin
// tie-breaking; default build uses fixed ALU-over-LSB priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W      = ID_WIDTH,
  parameter int unsigned VAL_W      = VAL_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [VAL_W-1:0] alu_val,
  output logic             alu_ready,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [VAL_W-1:0] lsb_val,
  output logic             lsb_ready,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [VAL_W-1:0] cdb_val
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  logic [TAG_W+VAL_W-1:0] w_alu_dout, w_lsb_dout;
  logic [CW-1:0]          w_alu_count, w_lsb_count;
  logic                   w_alu_full, w_lsb_full;
  logic                   w_alu_empty, w_lsb_empty;
  logic                   w_alu_push, w_lsb_push;
  logic                   w_alu_pop, w_lsb_pop;
  logic                   w_grant_any;
  src_e                   w_grant_src;
  src_e                   w_last;
  logic [TAG_W-1:0]       w_head_tag;
  logic [VAL_W-1:0]       w_head_val;

  assign alu_ready  = (w_alu_count != CNT_FULL);
  assign lsb_ready  = (w_lsb_count != CNT_FULL);
  assign w_alu_push = alu_valid && !w_alu_full && !flush;
  assign w_lsb_push = lsb_valid && !w_lsb_full && !flush;

  cdb_fifo #(.TAG_W(TAG_W), .VAL_W(VAL_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(flush),
    .push(w_alu_push), .pop(w_alu_pop), .din({alu_tag, alu_val}),
    .dout(w_alu_dout), .count(w_alu_count), .full(w_alu_full), .empty(w_alu_empty)
  );

  cdb_fifo #(.TAG_W(TAG_W), .VAL_W(VAL_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear(flush),
    .push(w_lsb_push), .pop(w_lsb_pop), .din({lsb_tag, lsb_val}),
    .dout(w_lsb_dout), .count(w_lsb_count), .full(w_lsb_full), .empty(w_lsb_empty)
  );

`ifdef CDB_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
  src_e r_last_grant;

  // Remember the last granted source; reset favours ALU on the first tie.
  always_ff @(posedge clk) begin
    if (rst_in)
      r_last_grant <= SRC_LSB;
    else if (rdy_in && !flush && w_grant_any)
      r_last_grant <= w_grant_src;
  end

  assign w_last = r_last_grant;
`else
  localparam logic RR_EN = 1'b0;
  assign w_last = SRC_LSB;
`endif

  // Pick one non-empty head and mux its contents toward the CDB register.
  always_comb begin
    w_grant_any = !w_alu_empty || !w_lsb_empty;
    w_grant_src = arb_pick(!w_alu_empty, !w_lsb_empty, RR_EN, w_last);
    w_alu_pop   = w_grant_any && (w_grant_src == SRC_ALU);
    w_lsb_pop   = w_grant_any && (w_grant_src == SRC_LSB);
    if (w_grant_src == SRC_ALU) begin
      w_head_tag = w_alu_dout[TAG_W+VAL_W-1 -: TAG_W];
      w_head_val = w_alu_dout[VAL_W-1:0];
    end else begin
      w_head_tag = w_lsb_dout[TAG_W+VAL_W-1 -: TAG_W];
      w_head_val = w_lsb_dout[VAL_W-1:0];
    end
  end

  // Registered broadcast; tag/value hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_val   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        cdb_valid <= 1'b0;
      end else if (w_grant_any) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= w_head_tag;
        cdb_val   <= w_head_val;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

  a_alu_no_overflow: assert property (@(posedge clk) disable iff (rst_in)
    (rdy_in && !flush && alu_valid) |-> alu_ready);
  a_lsb_no_overflow: assert property (@(posedge clk) disable iff (rst_in)
    (rdy_in && !flush && lsb_valid) |-> lsb_ready);
  a_alu_tag_nonzero: assert property (@(posedge clk) disable iff (rst_in)
    (rdy_in && !flush && alu_valid) |-> (alu_tag != '0));
  a_lsb_tag_nonzero: assert property (@(posedge clk) disable iff (rst_in)
    (rdy_in && !flush && lsb_valid) |-> (lsb_tag != '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table plus a burst
// sequence whose expected broadcast order depends on CDB_ARB_RR_EN.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst_in, rdy_in, flush;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_tag, lsb_tag;
  logic [31:0] alu_val, lsb_val;
  logic        alu_ready, lsb_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.TAG_W(4), .VAL_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_val(alu_val), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, rdy, fl;
    logic       av;
    logic [3:0] at;
    logic       lv;
    logic [3:0] lt;
    logic       ev;
    logic [3:0] et;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] val_of(input logic [3:0] t);
    return (t == 4'd0) ? 32'd0 : (32'hA000_0000 | {24'd0, t, 4'h0});
  endfunction

  function automatic vec_t mk(input logic rst, input logic rdy, input logic fl,
                              input logic av, input logic [3:0] at,
                              input logic lv, input logic [3:0] lt,
                              input logic ev, input logic [3:0] et);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.fl = fl;
    v.av = av; v.at = at; v.lv = lv; v.lt = lt;
    v.ev = ev; v.et = et;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic fl,
                      input logic av, input logic [3:0] at,
                      input logic lv, input logic [3:0] lt);
    rst_in = rst; rdy_in = rdy; flush = fl;
    alu_valid = av; alu_tag = at; alu_val = val_of(at);
    lsb_valid = lv; lsb_tag = lt; lsb_val = val_of(lt);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tagname, input int idx,
                           input logic ev, input logic [3:0] et,
                           input logic ear, input logic elr);
    check({tagname, "_valid"}, idx, {31'd0, cdb_valid}, {31'd0, ev});
    check({tagname, "_tag"},   idx, {28'd0, cdb_tag},   {28'd0, et});
    check({tagname, "_val"},   idx, cdb_val,            val_of(et));
    check({tagname, "_alu_rdy"}, idx, {31'd0, alu_ready}, {31'd0, ear});
    check({tagname, "_lsb_rdy"}, idx, {31'd0, lsb_ready}, {31'd0, elr});
  endtask

  logic [3:0] ord [8];
  logic       lrdy_exp [10];

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; alu_tag = '0; alu_val = '0;
    lsb_valid = 1'b0; lsb_tag = '0; lsb_val = '0;

    //                rst rdy fl  av at     lv lt     ev et
    tbl.push_back(mk(1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0));   // reset values
    tbl.push_back(mk(0, 1, 0, 1, 4'd3, 0, 4'd0, 0, 4'd0));   // push ALU tag 3
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd3));   // broadcast 2 edges later
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd3));   // one-cycle pulse, tag holds
    tbl.push_back(mk(0, 1, 0, 1, 4'd1, 0, 4'd0, 0, 4'd3));   // queue ALU 1
    tbl.push_back(mk(0, 0, 1, 1, 4'd2, 1, 4'd6, 0, 4'd3));   // flush/push with rdy low: no effect
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd1));   // ALU 1 survived
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd1));
    tbl.push_back(mk(0, 1, 0, 1, 4'd2, 1, 4'd5, 0, 4'd1));   // queue both
    tbl.push_back(mk(0, 1, 1, 1, 4'd4, 1, 4'd6, 0, 4'd1));   // flush drops queue and pushes
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd1));   // nothing stale
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd1));
    tbl.push_back(mk(0, 1, 0, 1, 4'd9, 0, 4'd0, 0, 4'd1));   // push ALU 9
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 1, 4'd10, 1, 4'd9));  // 9 out, LSB 10 queued
    tbl.push_back(mk(0, 0, 0, 0, 4'd0, 0, 4'd0, 1, 4'd9));   // frozen x3
    tbl.push_back(mk(0, 0, 0, 0, 4'd0, 0, 4'd0, 1, 4'd9));
    tbl.push_back(mk(0, 0, 0, 0, 4'd0, 0, 4'd0, 1, 4'd9));
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd10));  // next head follows
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd10));
    tbl.push_back(mk(0, 1, 0, 1, 4'd1, 0, 4'd0, 0, 4'd10));  // queue ALU 1
    tbl.push_back(mk(0, 1, 0, 1, 4'd2, 1, 4'd5, 1, 4'd1));   // 2 entries left queued
    tbl.push_back(mk(1, 1, 1, 1, 4'd7, 0, 4'd0, 0, 4'd0));   // reset outranks flush and push
    tbl.push_back(mk(0, 1, 0, 1, 4'd7, 0, 4'd0, 0, 4'd0));   // first push after reset
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd7));
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd7));   // queued results were discarded
    tbl.push_back(mk(1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0));   // reset again
    tbl.push_back(mk(0, 1, 0, 1, 4'd1, 1, 4'd5, 0, 4'd0));   // tie right after reset
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd1));   // ALU wins first tie
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd5));
    tbl.push_back(mk(0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd5));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].fl, tbl[i].av, tbl[i].at, tbl[i].lv, tbl[i].lt);
      check_out("vec", i, tbl[i].ev, tbl[i].et, 1'b1, 1'b1);
    end

`ifdef CDB_ARB_RR_EN
    ord = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8};
    for (int k = 0; k < 10; k++) lrdy_exp[k] = 1'b1;
`else
    ord = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    for (int k = 0; k < 10; k++) lrdy_exp[k] = !(k == 3 || k == 4);
`endif

    // Burst: both sources push for 4 cycles, then drain; pointers wrap.
    for (int k = 0; k < 10; k++) begin
      logic       ev;
      logic [3:0] et;
      if (k < 4)
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'(k + 1), 1'b1, 4'(k + 5));
      else
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      ev = (k >= 1 && k <= 8);
      if (k == 0)      et = 4'd5;
      else if (k <= 8) et = ord[k - 1];
      else             et = ord[7];
      check_out("burst", k, ev, et, 1'b1, lrdy_exp[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
